// File: rtl/display_sequencer_pkg.sv
// Shared types and constants for the display sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: view state enum, blank digit code, decimal-point masks,
// reset display word and a saturating 8-bit increment helper.
package display_seq_pkg;

  typedef enum logic {
    S_TIME = 1'b0,
    S_DATE = 1'b1
  } state_t;

  // The LED scanner blanks any digit carrying code F.
  localparam logic [3:0]  DIGIT_BLANK = 4'hF;

  // point[i] lights the DP of led(i+1): bits 4 and 2 sit after led5 and led3,
  // i.e. after H0/M0 in TIME view and after Y0/Mo0 in DATE view.
  localparam logic [7:0]  POINT_TIME  = 8'b0001_0100;
  localparam logic [7:0]  POINT_DATE  = 8'b0001_0100;

  localparam logic [39:0] DISP_RESET  = 40'hFFFF_FFFF_00;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Bundles the data-side signals of the display sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or pulses.
//
// master: source of button/tick/BCD inputs, sink of the display bus.
// slave : the sequencer itself.
interface display_sequencer_if;

  logic        btn0;          // raw push button, asynchronous, active high
  logic        tick_1hz;      // one-cycle pulse per second
  logic [23:0] time_bcd;      // {H1,H0,M1,M0,S1,S0}
  logic [31:0] date_bcd;      // {Y3,Y2,Y1,Y0,Mo1,Mo0,D1,D0}
  logic [39:0] display_bcd;   // {led8..led1 digit codes, point[7:0]}
  logic        display_year;  // 1 while DATE view is shown

  modport master (
    output btn0, tick_1hz, time_bcd, date_bcd,
    input  display_bcd, display_year
  );

  modport slave (
    input  btn0, tick_1hz, time_bcd, date_bcd,
    output display_bcd, display_year
  );

endinterface

// File: rtl/display_sequencer_btn_debounce.sv
// Synchronises and debounces a raw push button, emitting one pulse per accepted press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, then press pulses for 1 cycle.
// Backpressure: none; press is a fire-and-forget pulse.
//
// Ports: clk, reset_n (sync, active low), btn_in (raw async),
//        level (debounced level), press (1-cycle pulse on accepted 0->1).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      // Any sample that agrees with the accepted level restarts the run, so
      // only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
      if (sync_q2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        level      <= sync_q2;
        press      <= sync_q2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Chooses TIME or DATE view for the 8-digit scanner; button toggles, DATE auto-returns.
// Latency: display_bcd/display_year are registered, 1 cycle after an input or state change.
// Backpressure: none; the display bus is a continuously refreshed level.
//
// Ports: clk, reset_n (sync, active low), bus (display_sequencer_if.slave:
//        btn0, tick_1hz, time_bcd, date_bcd in; display_bcd, display_year out).
// Build option: DISPLAY_SEQ_AUTOCYCLE_EN adds an idle timer that switches
//        TIME -> DATE after AUTO_CYCLE_S seconds without a press.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DATE_HOLD_S     = 5,
  parameter int unsigned AUTO_CYCLE_S    = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  display_sequencer_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(DATE_HOLD_S - 1);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic        press;
  logic [39:0] display_q;
  logic        year_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_in  (bus.btn0),
    .level   (),
    .press   (press)
  );

`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
  localparam logic [7:0] IDLE_LAST = 8'(AUTO_CYCLE_S - 1);
  logic [7:0] idle_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_TIME;
      hold_cnt  <= 8'd0;
`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
      idle_cnt  <= 8'd0;
`endif
      display_q <= DISP_RESET;
      year_q    <= 1'b0;
    end else begin
      // Output reflects the state and inputs as they were before this edge.
      if (state == S_DATE) begin
        display_q <= {bus.date_bcd, POINT_DATE};
        year_q    <= 1'b1;
      end else begin
        display_q <= {DIGIT_BLANK, DIGIT_BLANK, bus.time_bcd, POINT_TIME};
        year_q    <= 1'b0;
      end

      // Press is tested first so it wins over a coincident tick.
      case (state)
        S_TIME: begin
          if (press) begin
            state    <= S_DATE;
            hold_cnt <= 8'd0;
`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
            idle_cnt <= 8'd0;
          end else if (bus.tick_1hz) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= S_DATE;
              hold_cnt <= 8'd0;
              idle_cnt <= 8'd0;
            end else begin
              idle_cnt <= sat_inc8(idle_cnt);
            end
`endif
          end
        end
        S_DATE: begin
          if (press) begin
            state    <= S_TIME;
            hold_cnt <= 8'd0;
`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
            idle_cnt <= 8'd0;
`endif
          end else if (bus.tick_1hz) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= S_TIME;
              hold_cnt <= 8'd0;
`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
              idle_cnt <= 8'd0;
`endif
            end else begin
              hold_cnt <= sat_inc8(hold_cnt);
            end
          end
        end
        default: begin
          state    <= S_TIME;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bus.display_bcd  = display_q;
  assign bus.display_year = year_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed self-checking bench for display_sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_sequencer;

  logic clk;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  display_sequencer_if bus ();

  display_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .DATE_HOLD_S     (3),
    .AUTO_CYCLE_S    (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tick pulse spanning exactly one rising edge; returns on the negedge after it.
  task automatic do_tick();
    @(negedge clk) bus.tick_1hz = 1'b1;
    @(negedge clk) bus.tick_1hz = 1'b0;
  endtask

  // Clean press: the FSM sees the press on the 7th rising edge after btn0 rises
  // (2 sync edges, 4 debounce samples, 1 pulse register). Optionally a tick is
  // placed on that same edge. Button is then released and allowed to settle.
  task automatic do_press(input logic with_tick);
    @(negedge clk) bus.btn0 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk) bus.tick_1hz = with_tick;
    @(negedge clk) bus.tick_1hz = 1'b0;
    repeat (4) @(negedge clk);
    bus.btn0 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int   cyc;
    logic stuck;

    reset_n          = 1'b0;
    bus.btn0         = 1'b0;
    bus.tick_1hz     = 1'b0;
    bus.time_bcd     = 24'h123456;
    bus.date_bcd     = 32'h20240827;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_disp", bus.display_bcd, 40'hFFFF_FFFF_00);
    check("reset_year", bus.display_year, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_time", bus.display_bcd, 40'hFF123456_14);
    check("post_reset_year", bus.display_year, 1'b0);

    // TIME format and 1-cycle latency
    bus.time_bcd = 24'h235958;
    check("time_latency_old", bus.display_bcd, 40'hFF123456_14);
    @(negedge clk);
    check("time_format", bus.display_bcd, 40'hFF235958_14);

    // Bounce rejection: toggle every 2 cycles for 20 cycles
    for (int i = 0; i < 10; i++) begin
      bus.btn0 = (i % 2 == 0);
      repeat (2) @(negedge clk);
      check("bounce_no_press", bus.display_year, 1'b0);
    end
    bus.btn0 = 1'b1;
    cyc = 0;
    while (bus.display_year !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("press_latency", 40'(cyc), 40'd8);
    check("date_format", bus.display_bcd, 40'h20240827_14);
    // Holding the button must not produce further presses
    stuck = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.display_year !== 1'b1) stuck = 1'b0;
    end
    check("held_single_press", stuck, 1'b1);
    bus.btn0 = 1'b0;
    repeat (10) @(negedge clk);
    check("release_no_press", bus.display_year, 1'b1);

    // Hold timeout: 3 ticks in DATE
    do_tick();
    check("hold_tick1", bus.display_year, 1'b1);
    do_tick();
    check("hold_tick2", bus.display_year, 1'b1);
    do_tick();
    check("hold_tick3_same", bus.display_year, 1'b1);
    @(negedge clk);
    check("hold_expire_year", bus.display_year, 1'b0);
    check("hold_expire_disp", bus.display_bcd, 40'hFF235958_14);

    // Press + tick with hold_cnt == 2: press wins
    do_press(1'b0);
    check("reenter_date", bus.display_year, 1'b1);
    do_tick();
    do_tick();
    check("hold2_date", bus.display_year, 1'b1);
    do_press(1'b1);
    check("press_tick_year", bus.display_year, 1'b0);
    check("press_tick_disp", bus.display_bcd, 40'hFF235958_14);
    repeat (10) @(negedge clk);
    check("press_tick_stays", bus.display_year, 1'b0);

    // Re-entry clears hold_cnt: two ticks stay, third leaves
    do_press(1'b0);
    check("second_press_date", bus.display_year, 1'b1);
    do_tick();
    do_tick();
    check("hold_cleared", bus.display_year, 1'b1);
    do_tick();
    @(negedge clk);
    check("hold_cleared_exit", bus.display_year, 1'b0);

    // Out-of-range BCD codes pass through unchanged
    bus.time_bcd = 24'hABCDEF;
    @(negedge clk);
    check("bcd_passthrough", bus.display_bcd, 40'hFFABCDEF_14);

`ifdef DISPLAY_SEQ_AUTOCYCLE_EN
    repeat (4) do_tick();
    check("auto_4_ticks", bus.display_year, 1'b0);
    do_tick();
    check("auto_5th_same", bus.display_year, 1'b0);
    @(negedge clk);
    check("auto_to_date", bus.display_year, 1'b1);
    repeat (3) do_tick();
    @(negedge clk);
    check("auto_return", bus.display_year, 1'b0);
`else
    repeat (10) do_tick();
    @(negedge clk);
    check("no_auto_cycle", bus.display_year, 1'b0);
`endif

    // Reset mid-operation from DATE
    do_press(1'b0);
    check("pre_reset_date", bus.display_year, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset_disp", bus.display_bcd, 40'hFFFF_FFFF_00);
    check("mid_reset_year", bus.display_year, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("after_reset_time", bus.display_bcd, 40'hFFABCDEF_14);
    check("after_reset_year", bus.display_year, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
